// File: rtl/uart_tx_sched.sv
// Byte scheduler in front of a PIC-style UART transmitter.
// Programs SPBRG/TXSTA, then round-robins two requesters into TXREG.
module uart_tx_sched #(
  parameter logic [7:0] SPBRG_INIT = 8'd25,
  parameter logic       BRGH_INIT  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_start,
  input  logic [7:0] cfg_spbrg,
  input  logic       cfg_brgh,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       txif_in,
  input  logic       trmt_in,
  output logic [7:0] reg_data_out,
  output logic       spbrg_reg_wr_en,
  output logic       txsta_reg_wr_en,
  output logic       txreg_reg_wr_en,
  output logic       cfg_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    CFG_BRG,
    CFG_TXSTA,
    IDLE,
    ISSUE,
    WAIT_LO,
    DRAIN
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       cfg_pend;
  logic       last_grant;
  logic [7:0] hold;
  logic [7:0] cur_spbrg;
  logic       cur_brgh;
  logic       gnt0;
  logic       gnt1;
  logic       any_gnt;
  logic       drain_ok;

  assign drain_ok = txif_in & trmt_in;

  // last_grant=1 means req1 was served last, so req0 wins a tie
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst && state == IDLE && !cfg_pend && txif_in) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign any_gnt    = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CFG_BRG;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CFG_BRG:   state_nxt = CFG_TXSTA;
      CFG_TXSTA: state_nxt = IDLE;
      IDLE: begin
        if (cfg_pend)     state_nxt = DRAIN;
        else if (any_gnt) state_nxt = ISSUE;
      end
      ISSUE:     state_nxt = WAIT_LO;
      WAIT_LO:   if (!txif_in) state_nxt = IDLE;
      DRAIN:     if (drain_ok) state_nxt = CFG_BRG;
      default:   state_nxt = CFG_BRG;
    endcase
  end

  always_comb begin
    spbrg_reg_wr_en = 1'b0;
    txsta_reg_wr_en = 1'b0;
    txreg_reg_wr_en = 1'b0;
    reg_data_out    = 8'd0;
    if (rst) begin
      unique case (1'b1)
        state == CFG_BRG: begin
          spbrg_reg_wr_en = 1'b1;
          reg_data_out    = cur_spbrg;
        end
        state == CFG_TXSTA: begin
          txsta_reg_wr_en = 1'b1;
          reg_data_out    = {2'b00, 1'b1, 2'b00,
                             cur_brgh, 2'b00};
        end
        state == ISSUE: begin
          txreg_reg_wr_en = 1'b1;
          reg_data_out    = hold;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_pend   <= 1'b0;
      last_grant <= 1'b1;
      hold       <= 8'd0;
      cur_spbrg  <= SPBRG_INIT;
      cur_brgh   <= BRGH_INIT;
    end else begin
      if (cfg_start) begin
        cfg_pend  <= 1'b1;
        cur_spbrg <= cfg_spbrg;
        cur_brgh  <= cfg_brgh;
      end else if (state == DRAIN && drain_ok) begin
        cfg_pend <= 1'b0;
      end
      if (any_gnt) begin
        hold       <= gnt1 ? req1_data : req0_data;
        last_grant <= gnt1;
      end
    end
  end

  assign cfg_done = (state == IDLE || state == ISSUE ||
                     state == WAIT_LO) && !cfg_pend;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: config, arbitration,
// reconfiguration drain and reset-abort sequences.
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic [7:0] cfg_spbrg;
  logic       cfg_brgh;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       txif_in;
  logic       trmt_in;
  logic [7:0] reg_data_out;
  logic       spbrg_reg_wr_en;
  logic       txsta_reg_wr_en;
  logic       txreg_reg_wr_en;
  logic       cfg_done;
  logic       busy;

  int n_asrt = 0;
  int n_fail = 0;

  uart_tx_sched dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_start       (cfg_start),
    .cfg_spbrg       (cfg_spbrg),
    .cfg_brgh        (cfg_brgh),
    .req0_valid      (req0_valid),
    .req0_data       (req0_data),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_data       (req1_data),
    .req1_ready      (req1_ready),
    .txif_in         (txif_in),
    .trmt_in         (trmt_in),
    .reg_data_out    (reg_data_out),
    .spbrg_reg_wr_en (spbrg_reg_wr_en),
    .txsta_reg_wr_en (txsta_reg_wr_en),
    .txreg_reg_wr_en (txreg_reg_wr_en),
    .cfg_done        (cfg_done),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // strobes packed as {spbrg, txsta, txreg}
  task automatic chk_bus(input string tag,
                         input logic [2:0] stb,
                         input logic [7:0] dat);
    chk({tag, "_stb"},
        {29'd0, spbrg_reg_wr_en, txsta_reg_wr_en, txreg_reg_wr_en},
        {29'd0, stb});
    chk({tag, "_dat"}, {24'd0, reg_data_out}, {24'd0, dat});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst        = 1'b0;
    cfg_start  = 1'b0;
    cfg_spbrg  = 8'd0;
    cfg_brgh   = 1'b0;
    req0_valid = 1'b0;
    req0_data  = 8'd0;
    req1_valid = 1'b0;
    req1_data  = 8'd0;
    txif_in    = 1'b1;
    trmt_in    = 1'b1;

    // reset state
    #3;
    chk_bus("rst", 3'b000, 8'h00);
    chk("rst_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_done", {31'd0, cfg_done}, 32'd0);

    // power-up configuration
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_bus("brg0", 3'b100, 8'd25);
    tick();
    chk_bus("txsta0", 3'b010, 8'h24);
    tick();
    chk_bus("idle0", 3'b000, 8'h00);
    chk("done0", {31'd0, cfg_done}, 32'd1);
    chk("busy0", {31'd0, busy}, 32'd0);

    // round robin under continuous contention
    req0_valid = 1'b1;
    req0_data  = 8'h11;
    req1_valid = 1'b1;
    req1_data  = 8'h22;
    for (int i = 0; i < 4; i++) begin
      txif_in = 1'b1;
      #1;
      chk("rr_rdy0", {31'd0, req0_ready}, {31'd0, i[0] == 1'b0});
      chk("rr_rdy1", {31'd0, req1_ready}, {31'd0, i[0] == 1'b1});
      tick();
      chk_bus("rr_wr", 3'b001, (i[0] == 1'b0) ? 8'h11 : 8'h22);
      txif_in = 1'b0;
      tick();
      chk_bus("rr_wlo", 3'b000, 8'h00);
      tick();
      chk("rr_busy", {31'd0, busy}, 32'd0);
      chk("rr_hold", {30'd0, req0_ready, req1_ready}, 32'd0);
    end
    req1_valid = 1'b0;

    // single byte, WAIT_LO holds while txif stays high
    req0_data = 8'hA5;
    txif_in   = 1'b1;
    #1;
    chk("a5_rdy", {30'd0, req0_ready, req1_ready}, 32'd2);
    tick();
    req0_valid = 1'b0;
    #1;
    chk_bus("a5_wr", 3'b001, 8'hA5);
    chk("a5_rdy_off", {31'd0, req0_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bus("a5_wlo", 3'b000, 8'h00);
      chk("a5_busy", {31'd0, busy}, 32'd1);
    end
    txif_in = 1'b0;
    tick();
    chk("a5_idle", {31'd0, busy}, 32'd0);

    // txif low blocks grants
    req0_valid = 1'b1;
    req0_data  = 8'h77;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("txlo_rdy", {31'd0, req0_ready}, 32'd0);
      chk("txlo_wr", {31'd0, txreg_reg_wr_en}, 32'd0);
      tick();
    end

    // reconfiguration: second request overwrites the first
    req0_data = 8'h33;
    cfg_start = 1'b1;
    cfg_spbrg = 8'h40;
    cfg_brgh  = 1'b1;
    tick();
    cfg_start = 1'b0;
    #1;
    chk("cfg_pend_done", {31'd0, cfg_done}, 32'd0);
    trmt_in = 1'b0;
    txif_in = 1'b1;
    #1;
    chk("cfg_prio", {31'd0, req0_ready}, 32'd0);
    tick();
    cfg_start = 1'b1;
    cfg_spbrg = 8'h0C;
    cfg_brgh  = 1'b0;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_bus("drain", 3'b000, 8'h00);
      chk("drain_rdy", {31'd0, req0_ready}, 32'd0);
      chk("drain_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    trmt_in = 1'b1;
    tick();
    chk_bus("brg1", 3'b100, 8'h0C);
    tick();
    chk_bus("txsta1", 3'b010, 8'h20);
    tick();
    chk("done1", {31'd0, cfg_done}, 32'd1);
    chk("held_rdy", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk_bus("held_wr", 3'b001, 8'h33);
    txif_in = 1'b0;
    tick();
    tick();
    chk("held_idle", {31'd0, busy}, 32'd0);

    // reset during WAIT_LO drops the byte
    txif_in    = 1'b1;
    req1_valid = 1'b1;
    req1_data  = 8'h5A;
    #1;
    chk("rw_rdy", {30'd0, req0_ready, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    #1;
    chk_bus("rw_wr", 3'b001, 8'h5A);
    tick();
    chk("rw_wlo", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk_bus("rw_rst", 3'b000, 8'h00);
    chk("rw_rst_done", {31'd0, cfg_done}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk_bus("brg2", 3'b100, 8'd25);
    tick();
    chk_bus("txsta2", 3'b010, 8'h24);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_bus("rw_norewr", 3'b000, 8'h00);
      chk("rw_idle", {31'd0, busy}, 32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
